// File: rtl/matmul_seq_ctrl_pkg.sv
// Shared types and defaults for the two-stage matrix-multiply sequencer.
package matmul_pkg;

   localparam int ROWS_DEF    = 8;
   localparam int ROW_W_DEF   = 64;
   localparam int WD_W        = 8;
   localparam int TIMEOUT_MAX = 255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN1,
      ST_XFER,
      ST_WAIT2,
      ST_DONE
   } state_e;

endpackage

// File: rtl/seq_row_buf.sv
// Row buffer between the two multiplier stages.
// One synchronous write port and one registered read port; the read register returns 0 when idle.
module seq_row_buf #(
   parameter int ROWS  = 8,
   parameter int ROW_W = 64,
   localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [ROW_W-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [ROW_W-1:0] rd_data_o
);

   logic [ROW_W-1:0] mem_q [ROWS];
   logic [ROW_W-1:0] rd_data_q;

   // NOTE: the array has no reset so it maps onto distributed RAM; every row is rewritten before it is read.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)      rd_data_q <= '0;
      else if (rd_en_i) rd_data_q <= mem_q[rd_idx_i];
      else              rd_data_q <= '0;
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer: collects stage-1 rows, streams them to stage 2, waits for stage-2 completion.
// Define MATMUL_SEQ_TIMEOUT_EN to build in the 8-bit RUN1/WAIT2 watchdog.
module matmul_seq_ctrl
   import matmul_pkg::*;
#(
   parameter int ROWS  = ROWS_DEF,
   parameter int ROW_W = ROW_W_DEF
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             start_i,
   input  logic             s1_done_i,
   input  logic [ROW_W-1:0] s1_res_i,
   input  logic             s2_done_i,
   output logic             s1_en_o,
   output logic             s2_en_o,
   output logic             s2_valid_o,
   output logic [ROW_W-1:0] s2_din_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);

   localparam int               IDX_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic             buf_wr;
   logic             buf_rd;
   logic             timeout;

`ifdef MATMUL_SEQ_TIMEOUT_EN
   logic [WD_W-1:0] wd_q, wd_d;

   assign timeout = ((state_q == ST_RUN1) || (state_q == ST_WAIT2)) &&
                    (wd_q == WD_W'(TIMEOUT_MAX));

   always_comb begin
      wd_d = '0;
      if (((state_q == ST_RUN1) || (state_q == ST_WAIT2)) &&
          (state_d == state_q) && !s1_done_i)
         wd_d = wd_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) wd_q <= '0;
      else         wd_q <= wd_d;
   end

   assign err_o = timeout;
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= ST_IDLE;
         wr_idx_q <= '0;
         rd_idx_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
      end
   end

   // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d  = state_q;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      buf_wr   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d  = ST_RUN1;
               wr_idx_d = '0;
               rd_idx_d = '0;
            end
         end
         ST_RUN1: begin
            if (timeout) begin
               state_d = ST_IDLE;
            end else if (s1_done_i) begin
               buf_wr = 1'b1;
               if (wr_idx_q == LAST_IDX) state_d  = ST_XFER;
               else                      wr_idx_d = wr_idx_q + 1'b1;
            end
         end
         ST_XFER: begin
            // rd_idx_q is the row on s2_din_o this cycle; rd_idx_d addresses the next one.
            if (rd_idx_q == LAST_IDX) state_d  = ST_WAIT2;
            else                      rd_idx_d = rd_idx_q + 1'b1;
         end
         ST_WAIT2: begin
            if (timeout)        state_d = ST_IDLE;
            else if (s2_done_i) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign buf_rd = (state_d == ST_XFER);

   seq_row_buf #(
      .ROWS  (ROWS),
      .ROW_W (ROW_W)
   ) u_buf (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .wr_en_i   (buf_wr),
      .wr_idx_i  (wr_idx_q),
      .wr_data_i (s1_res_i),
      .rd_en_i   (buf_rd),
      .rd_idx_i  (rd_idx_d),
      .rd_data_o (s2_din_o)
   );

   assign s1_en_o    = (state_q == ST_RUN1);
   assign s2_en_o    = (state_q == ST_XFER) || (state_q == ST_WAIT2);
   assign s2_valid_o = (state_q == ST_XFER);
   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: scoreboard of stage-1 rows checked against the XFER stream.
module tb_matmul_seq_ctrl;

   localparam int ROWS  = 8;
   localparam int ROW_W = 64;

   logic             clk_i     = 1'b0;
   logic             rstn_i    = 1'b0;
   logic             start_i   = 1'b0;
   logic             s1_done_i = 1'b0;
   logic [ROW_W-1:0] s1_res_i  = '0;
   logic             s2_done_i = 1'b0;
   logic             s1_en_o, s2_en_o, s2_valid_o, busy_o, done_o, err_o;
   logic [ROW_W-1:0] s2_din_o;

   int               vectors     = 0;
   int               miscompares = 0;
   logic [ROW_W-1:0] sb[$];

   always #5 clk_i = ~clk_i;

   matmul_seq_ctrl #(.ROWS(ROWS), .ROW_W(ROW_W)) dut (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .start_i    (start_i),
      .s1_done_i  (s1_done_i),
      .s1_res_i   (s1_res_i),
      .s2_done_i  (s2_done_i),
      .s1_en_o    (s1_en_o),
      .s2_en_o    (s2_en_o),
      .s2_valid_o (s2_valid_o),
      .s2_din_o   (s2_din_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_pass();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("run1_busy", busy_o, 1);
      chk("run1_s1_en", s1_en_o, 1);
   endtask

   task automatic feed_rows(input logic [7:0] base, input bit poke_start);
      for (int i = 0; i < ROWS; i++) begin
         s1_done_i = 1'b1;
         s1_res_i  = {8{8'(base * 8'(i + 1))}};
         if (poke_start && i == 3) start_i = 1'b1;
         sb.push_back(s1_res_i);
         tick();
         start_i = 1'b0;
      end
      s1_done_i = 1'b0;
      s1_res_i  = '0;
   endtask

   task automatic stream_rows(input int stop_at);
      int               t;
      logic [ROW_W-1:0] exp;
      t = 0;
      while (!s2_valid_o && t < 16) begin
         tick();
         t++;
      end
      chk("xfer_reached", s2_valid_o, 1);
      for (int k = 0; k < ROWS; k++) begin
         chk("sb_nonempty", sb.size() > 0, 1);
         exp = (sb.size() > 0) ? sb.pop_front() : '0;
         chk("xfer_valid", s2_valid_o, 1);
         chk("xfer_en", s2_en_o, 1);
         chk($sformatf("xfer_row%0d", k), s2_din_o, exp);
         if (k == stop_at) return;
         tick();
      end
      chk("wait2_valid", s2_valid_o, 0);
      chk("wait2_en", s2_en_o, 1);
      chk("wait2_din", s2_din_o, 0);
   endtask

   task automatic finish_pass(input int gap, input bit stray);
      for (int g = 0; g < gap; g++) begin
         if (stray && g == 1) begin
            s1_done_i = 1'b1;
            s1_res_i  = 64'hDEAD_BEEF_0BAD_F00D;
         end
         tick();
         s1_done_i = 1'b0;
         s1_res_i  = '0;
         chk("wait2_hold", s2_en_o, 1);
         chk("wait2_no_done", done_o, 0);
      end
      s2_done_i = 1'b1;
      tick();
      s2_done_i = 1'b0;
      chk("done_pulse", done_o, 1);
      chk("done_busy", busy_o, 1);
      chk("done_s2_en", s2_en_o, 0);
      tick();
      chk("idle_done_low", done_o, 0);
      chk("idle_busy", busy_o, 0);
   endtask

   initial begin
      int done_seen;
      int busy_seen;
      int n;

      #2;
      chk("rst_busy", busy_o, 0);
      chk("rst_s1_en", s1_en_o, 0);
      chk("rst_s2_en", s2_en_o, 0);
      chk("rst_s2_valid", s2_valid_o, 0);
      chk("rst_s2_din", s2_din_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      tick();
      tick();
      rstn_i = 1'b1;
      tick();

      // Nominal pass
      start_pass();
      feed_rows(8'h11, 1'b0);
      stream_rows(-1);
      finish_pass(3, 1'b0);

      // start_i during RUN1 is ignored: one done_o and no second pass
      start_pass();
      feed_rows(8'h21, 1'b1);
      stream_rows(-1);
      finish_pass(3, 1'b0);
      done_seen = 0;
      busy_seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done_o) done_seen++;
         if (busy_o) busy_seen++;
      end
      chk("no_extra_done", done_seen, 0);
      chk("no_extra_pass", busy_seen, 0);

      // Stray strobes in IDLE, then stray s1_done_i in WAIT2
      s1_done_i = 1'b1;
      s1_res_i  = 64'hBAD0_BAD0_BAD0_BAD0;
      s2_done_i = 1'b1;
      tick();
      s1_done_i = 1'b0;
      s1_res_i  = '0;
      s2_done_i = 1'b0;
      chk("stray_idle_busy", busy_o, 0);
      chk("stray_idle_s1_en", s1_en_o, 0);
      chk("stray_idle_done", done_o, 0);
      tick();
      start_pass();
      feed_rows(8'h31, 1'b0);
      stream_rows(-1);
      finish_pass(3, 1'b1);
      start_pass();
      feed_rows(8'h41, 1'b0);
      stream_rows(-1);
      finish_pass(2, 1'b0);

      // Reset during XFER row 3
      start_pass();
      feed_rows(8'h51, 1'b0);
      stream_rows(3);
      #1 rstn_i = 1'b0;
      #1;
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_s1_en", s1_en_o, 0);
      chk("mid_rst_s2_en", s2_en_o, 0);
      chk("mid_rst_s2_valid", s2_valid_o, 0);
      chk("mid_rst_s2_din", s2_din_o, 0);
      chk("mid_rst_done", done_o, 0);
      chk("mid_rst_err", err_o, 0);
      sb.delete();
      tick();
      rstn_i = 1'b1;
      tick();
      chk("post_rst_idle", busy_o, 0);
      start_pass();
      feed_rows(8'h61, 1'b0);
      stream_rows(-1);
      finish_pass(3, 1'b0);

`ifdef MATMUL_SEQ_TIMEOUT_EN
      // Watchdog abort in WAIT2
      start_pass();
      feed_rows(8'h91, 1'b0);
      stream_rows(-1);
      n = 0;
      while (!err_o && n < 300) begin
         tick();
         n++;
      end
      chk("wd_latency", n, 255);
      chk("wd_err", err_o, 1);
      chk("wd_no_done", done_o, 0);
      tick();
      chk("wd_idle", busy_o, 0);
      chk("wd_err_pulse", err_o, 0);
      chk("wd_done_after", done_o, 0);
`endif

      // Back-to-back passes
      start_pass();
      feed_rows(8'h71, 1'b0);
      stream_rows(-1);
      finish_pass(3, 1'b0);
      start_pass();
      feed_rows(8'h83, 1'b0);
      stream_rows(-1);
      finish_pass(1, 1'b0);
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/matmul_seq_ctrl.md
MATMUL_SEQ_CTRL -- requirements
Module: matmul_seq_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 8: rows per matrix pass; also the stage-1 result count.
REQ-002 SHALL have parameter ROW_W, default 64: width of one packed row (8 x 8-bit).
REQ-003 SHALL have ports:
- clk_i  in  1: single clock, all logic on rising edge.
- rstn_i  in  1: asynchronous, active-low reset.
- start_i  in  1: one-cycle pass request; accepted only in IDLE.
- s1_done_i  in  1: stage-1 multiplier row-result strobe.
- s1_res_i  in  ROW_W: stage-1 row result, valid with s1_done_i.
- s2_done_i  in  1: stage-2 multiplier completion strobe.
- s1_en_o  out  1: stage-1 enable.
- s2_en_o  out  1: stage-2 enable.
- s2_valid_o  out  1: stage-2 row-valid.
- s2_din_o  out  ROW_W: stage-2 row data.
- busy_o  out  1: high whenever state is not IDLE.
- done_o  out  1: one-cycle pass-complete pulse.
- err_o  out  1: one-cycle watchdog-abort pulse; tied 0 when the watchdog is compiled out.

Function
REQ-004 SHALL implement FSM IDLE -> RUN1 -> XFER -> WAIT2 -> DONE -> IDLE.
REQ-005 SHALL leave IDLE for RUN1 on the cycle after start_i=1 is sampled; start_i SHALL be ignored in every other state.
REQ-006 In RUN1, s1_en_o SHALL be 1 and each s1_done_i=1 SHALL write s1_res_i to buffer[wr_idx], then increment wr_idx.
REQ-007 When the write at wr_idx=ROWS-1 occurs, the FSM SHALL enter XFER on the next cycle, with no wrap-around write.
REQ-008 s1_done_i outside RUN1 SHALL be ignored and the buffer SHALL not change.
REQ-009 XFER SHALL last exactly ROWS cycles:
- s2_en_o=1 and s2_valid_o=1 on every XFER cycle.
- s2_din_o=buffer[k] on XFER cycle k, k=0..ROWS-1, registered output.
- Next state after the last row is WAIT2.
REQ-010 In WAIT2, s2_en_o SHALL be 1, s2_valid_o SHALL be 0 and s2_din_o SHALL be 0; s2_done_i=1 SHALL move the FSM to DONE.
REQ-011 DONE SHALL last one cycle with done_o=1, then return to IDLE; s2_done_i outside WAIT2 SHALL be ignored.
REQ-012 Latency from start_i to done_o SHALL be (RUN1 cycles) + ROWS + (WAIT2 cycles) + 2 cycles.
REQ-013 wr_idx and rd_idx SHALL be clog2(ROWS) bits and SHALL clear on entry to RUN1.

Reset
REQ-014 On rstn_i=0, at any state including mid-pass, the FSM SHALL go to IDLE immediately.
REQ-015 Reset SHALL clear all outputs, wr_idx, rd_idx and the watchdog counter to 0.
REQ-016 Buffer contents SHALL be don't-care after reset and SHALL never be read before being rewritten in the current pass.

Configuration
REQ-017 With MATMUL_SEQ_TIMEOUT_EN defined, an 8-bit watchdog SHALL run as follows:
- Counts cycles in RUN1 and WAIT2; clears on every state change and on every s1_done_i.
- On reaching 255, err_o pulses 1 for one cycle and the FSM returns to IDLE without asserting done_o.
REQ-018 Without MATMUL_SEQ_TIMEOUT_EN, no watchdog logic SHALL exist, err_o SHALL be constant 0, and RUN1/WAIT2 SHALL wait indefinitely.

Structure
REQ-019 Package matmul_pkg SHALL hold the FSM state enum, the ROWS and ROW_W defaults and the TIMEOUT_MAX=255 constant.
REQ-020 The ROWS x ROW_W distributed-RAM buffer SHALL be sub-module seq_row_buf, with one synchronous write port and one registered read port.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Nominal pass: start_i, 8 s1_done_i with rows 0x11..0x88, s2_done_i 3 cycles after XFER -> s2_din_o = 0x11..0x88 on 8 consecutive cycles, then a single done_o pulse.
- start_i while in RUN1 -> ignored; exactly one done_o for the pass.
- Stray s1_done_i in IDLE and in WAIT2 -> buffer unchanged; next pass streams only the new data.
- rstn_i low during XFER row 3 -> all outputs 0 immediately; a new start_i completes a normal pass.
- With MATMUL_SEQ_TIMEOUT_EN, no s2_done_i -> err_o pulse 255 cycles after WAIT2 entry, FSM back in IDLE, no done_o.
- Back-to-back passes (start_i the cycle after done_o) -> second pass output correct with no leftover rows from the first.
